// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE 16-bit datapath control slice.
// The phase encoding is visible on the sequencer's phase output:
// 0 = IDLE, 1..5 = P1..P5.
package simple_pkg;

  localparam int unsigned PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE = 3'd0,
    PH_P1   = 3'd1,
    PH_P2   = 3'd2,
    PH_P3   = 3'd3,
    PH_P4   = 3'd4,
    PH_P5   = 3'd5
  } phase_t;

endpackage

// File: rtl/simple_edge_rise.sv
// Single-bit rising-edge detector. Produces one pulse per low-to-high
// transition, so holding a button high yields exactly one event.
module simple_edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic evt
);

  logic in_q;

  // Remember the previous level of the input
  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign evt = in & ~in_q;

endmodule

// File: rtl/simple_run_sequencer.sv
// Run-control and phase sequencer for the SIMPLE datapath.
// Steps P1..P5 per instruction and handles run/stop, single-step, HLT
// and bounded memory-wait stalls in P4.
// Optional feature: define SEQ_INSTR_COUNT_EN to build the retired-
// instruction counter; otherwise instr_cnt is tied to zero.
module simple_run_sequencer
  import simple_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec,
  input  logic             step,
  input  logic             halt_i,
  input  logic             mem_wait,
  output logic [2:0]       phase,
  output logic [4:0]       ph_oh,
  output logic             ir_e,
  output logic             pc_e,
  output logic             running,
  output logic             halted,
  output logic             wait_tmo,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  logic exec_evt, step_evt;

  phase_t         phase_q, phase_d;
  logic           running_q, running_d;
  logic           halted_q, halted_d;
  logic           wait_tmo_q, wait_tmo_d;
  logic           stop_req_q, stop_req_d;
  logic           step_mode_q, step_mode_d;
  logic           hlt_seen_q, hlt_seen_d;
  logic [WCW-1:0] wait_ctr_q, wait_ctr_d;

  simple_edge_rise u_exec_edge (
    .clk (clk),
    .rst (rst),
    .in  (exec),
    .evt (exec_evt)
  );

  simple_edge_rise u_step_edge (
    .clk (clk),
    .rst (rst),
    .in  (step),
    .evt (step_evt)
  );

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PH_IDLE;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      wait_tmo_q  <= 1'b0;
      stop_req_q  <= 1'b0;
      step_mode_q <= 1'b0;
      hlt_seen_q  <= 1'b0;
      wait_ctr_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      wait_tmo_q  <= wait_tmo_d;
      stop_req_q  <= stop_req_d;
      step_mode_q <= step_mode_d;
      hlt_seen_q  <= hlt_seen_d;
      wait_ctr_q  <= wait_ctr_d;
    end
  end

  // Next-phase and run-control flag logic
  always_comb begin
    phase_d     = phase_q;
    running_d   = running_q;
    halted_d    = halted_q;
    wait_tmo_d  = wait_tmo_q;
    stop_req_d  = stop_req_q;
    step_mode_d = step_mode_q;
    hlt_seen_d  = hlt_seen_q;
    wait_ctr_d  = wait_ctr_q;

    if (phase_q != PH_IDLE && exec_evt) stop_req_d = 1'b1;

    case (phase_q)
      PH_IDLE: begin
        if (exec_evt) begin
          phase_d     = PH_P1;
          running_d   = 1'b1;
          step_mode_d = 1'b0;
          halted_d    = 1'b0;
          wait_tmo_d  = 1'b0;
          stop_req_d  = 1'b0;
        end else if (step_evt) begin
          phase_d     = PH_P1;
          running_d   = 1'b1;
          step_mode_d = 1'b1;
          halted_d    = 1'b0;
          stop_req_d  = 1'b0;
        end
      end
      PH_P1: phase_d = PH_P2;
      PH_P2: begin
        phase_d = PH_P3;
        if (halt_i) hlt_seen_d = 1'b1;
      end
      PH_P3: phase_d = PH_P4;
      PH_P4: begin
        if (!mem_wait) begin
          phase_d    = PH_P5;
          wait_ctr_d = '0;
        end else if (wait_ctr_q == WAIT_LAST) begin
          phase_d    = PH_P5;
          wait_tmo_d = 1'b1;
          wait_ctr_d = '0;
        end else begin
          wait_ctr_d = wait_ctr_q + WCW'(1);
        end
      end
      PH_P5: begin
        // An exec press during P5 itself still stops at this boundary.
        if (stop_req_q || exec_evt || step_mode_q || hlt_seen_q) begin
          phase_d    = PH_IDLE;
          running_d  = 1'b0;
          stop_req_d = 1'b0;
          halted_d   = hlt_seen_q;
        end else begin
          phase_d = PH_P1;
        end
        hlt_seen_d = 1'b0;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // Per-phase strobes decoded from the registered phase
  always_comb begin
    ph_oh = '0;
    case (phase_q)
      PH_P1:   ph_oh = 5'b00001;
      PH_P2:   ph_oh = 5'b00010;
      PH_P3:   ph_oh = 5'b00100;
      PH_P4:   ph_oh = 5'b01000;
      PH_P5:   ph_oh = 5'b10000;
      default: ph_oh = '0;
    endcase
  end

  assign phase    = phase_q;
  assign ir_e     = (phase_q == PH_P1);
  assign pc_e     = (phase_q == PH_P5) && !hlt_seen_q;
  assign running  = running_q;
  assign halted   = halted_q;
  assign wait_tmo = wait_tmo_q;

`ifdef SEQ_INSTR_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count retiring instructions; P5 lasts one cycle so pc_e marks its exit
  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (pc_e) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_simple_run_sequencer.sv
// Self-checking bench for simple_run_sequencer: a table of per-cycle
// {inputs, expected outputs} records driven through a scoreboard queue,
// plus hand-written reset and instruction-count sequences.
module tb_simple_run_sequencer;
  import simple_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, exec, step, halt_i, mem_wait;
  logic [2:0]       phase;
  logic [4:0]       ph_oh;
  logic             ir_e, pc_e, running, halted, wait_tmo;
  logic [CNT_W-1:0] instr_cnt;

  simple_run_sequencer #(.CNT_W(CNT_W), .WAIT_LIMIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .exec      (exec),
    .step      (step),
    .halt_i    (halt_i),
    .mem_wait  (mem_wait),
    .phase     (phase),
    .ph_oh     (ph_oh),
    .ir_e      (ir_e),
    .pc_e      (pc_e),
    .running   (running),
    .halted    (halted),
    .wait_tmo  (wait_tmo),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e, s, h, m;
    int unsigned ph;
    logic        run, pce, hl, wt;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  function automatic void add(logic e, logic s, logic h, logic m, int unsigned ph,
                              logic run, logic pce, logic hl, logic wt);
    vec_t v;
    v.e = e; v.s = s; v.h = h; v.m = m;
    v.ph = ph; v.run = run; v.pce = pce; v.hl = hl; v.wt = wt;
    tbl.push_back(v);
  endfunction

  function automatic logic [4:0] oh_of(int unsigned ph);
    return (ph == 0) ? 5'd0 : 5'(5'd1 << (ph - 1));
  endfunction

  task automatic chk(string name, int unsigned idx, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int unsigned idx);
    vec_t e;
    exec = v.e; step = v.s; halt_i = v.h; mem_wait = v.m;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("phase",    idx, 32'(phase),    32'(e.ph));
    chk("ph_oh",    idx, 32'(ph_oh),    32'(oh_of(e.ph)));
    chk("ir_e",     idx, 32'(ir_e),     32'(e.ph == 1));
    chk("pc_e",     idx, 32'(pc_e),     32'(e.pce));
    chk("running",  idx, 32'(running),  32'(e.run));
    chk("halted",   idx, 32'(halted),   32'(e.hl));
    chk("wait_tmo", idx, 32'(wait_tmo), 32'(e.wt));
  endtask

  initial begin
    logic [CNT_W-1:0] exp_cnt;
    vec_t v;

    rst = 1'b1; exec = 1'b0; step = 1'b0; halt_i = 1'b0; mem_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase",   0, 32'(phase),     32'd0);
    chk("rst_ph_oh",   0, 32'(ph_oh),     32'd0);
    chk("rst_running", 0, 32'(running),   32'd0);
    chk("rst_halted",  0, 32'(halted),    32'd0);
    chk("rst_wt",      0, 32'(wait_tmo),  32'd0);
    chk("rst_pc_e",    0, 32'(pc_e),      32'd0);
    chk("rst_cnt",     0, 32'(instr_cnt), 32'd0);
    rst = 1'b0;

    // 1: free run from exec pulse
    add(1,0,0,0, 1,1,0,0,0);
    add(0,0,0,0, 2,1,0,0,0); add(0,0,0,0, 3,1,0,0,0); add(0,0,0,0, 4,1,0,0,0);
    add(0,0,0,0, 5,1,1,0,0); add(0,0,0,0, 1,1,0,0,0); add(0,0,0,0, 2,1,0,0,0);
    add(0,0,0,0, 3,1,0,0,0); add(0,0,0,0, 4,1,0,0,0); add(0,0,0,0, 5,1,1,0,0);
    add(0,0,0,0, 1,1,0,0,0); add(0,0,0,0, 2,1,0,0,0);
    // 2: exec press in P3 finishes the instruction then stops
    add(0,0,0,0, 3,1,0,0,0); add(1,0,0,0, 4,1,0,0,0); add(0,0,0,0, 5,1,1,0,0);
    add(0,0,0,0, 0,0,0,0,0); add(0,0,0,0, 0,0,0,0,0);
    // 3: single step, then exec+step together runs free; step while running ignored
    add(0,1,0,0, 1,1,0,0,0); add(0,0,0,0, 2,1,0,0,0); add(0,0,0,0, 3,1,0,0,0);
    add(0,0,0,0, 4,1,0,0,0); add(0,0,0,0, 5,1,1,0,0); add(0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0);
    add(1,1,0,0, 1,1,0,0,0); add(0,0,0,0, 2,1,0,0,0); add(0,1,0,0, 3,1,0,0,0);
    add(0,0,0,0, 4,1,0,0,0); add(0,0,0,0, 5,1,1,0,0); add(0,0,0,0, 1,1,0,0,0);
    add(1,0,0,0, 2,1,0,0,0); add(0,0,0,0, 3,1,0,0,0); add(0,0,0,0, 4,1,0,0,0);
    add(0,0,0,0, 5,1,1,0,0); add(0,0,0,0, 0,0,0,0,0);
    // 4: HLT in P2 suppresses pc_e and sets halted; next exec clears it
    add(1,0,0,0, 1,1,0,0,0); add(0,0,0,0, 2,1,0,0,0); add(0,0,1,0, 3,1,0,0,0);
    add(0,0,0,0, 4,1,0,0,0); add(0,0,0,0, 5,1,0,0,0); add(0,0,0,0, 0,0,0,1,0);
    add(0,0,0,0, 0,0,0,1,0);
    add(1,0,0,0, 1,1,0,0,0); add(0,0,0,0, 2,1,0,0,0); add(1,0,0,0, 3,1,0,0,0);
    add(0,0,0,0, 4,1,0,0,0); add(0,0,0,0, 5,1,1,0,0); add(0,0,0,0, 0,0,0,0,0);
    // 5: short stall (P4 lasts 4 cycles), then a stall that hits the limit (8 cycles)
    add(1,0,0,0, 1,1,0,0,0); add(0,0,0,0, 2,1,0,0,0); add(0,0,0,0, 3,1,0,0,0);
    add(0,0,0,0, 4,1,0,0,0);
    add(0,0,0,1, 4,1,0,0,0); add(0,0,0,1, 4,1,0,0,0); add(0,0,0,1, 4,1,0,0,0);
    add(0,0,0,0, 5,1,1,0,0);
    add(0,0,0,0, 1,1,0,0,0); add(0,0,0,0, 2,1,0,0,0); add(0,0,0,0, 3,1,0,0,0);
    add(0,0,0,0, 4,1,0,0,0);
    for (int i = 0; i < 7; i++) add(0,0,0,1, 4,1,0,0,0);
    add(0,0,0,1, 5,1,1,0,1);
    add(0,0,0,0, 1,1,0,0,1); add(1,0,0,0, 2,1,0,0,1); add(0,0,0,0, 3,1,0,0,1);
    add(0,0,0,0, 4,1,0,0,1); add(0,0,0,0, 5,1,1,0,1); add(0,0,0,0, 0,0,0,0,1);
    add(1,0,0,0, 1,1,0,0,0); add(0,0,0,0, 2,1,0,0,0); add(1,0,0,0, 3,1,0,0,0);
    add(0,0,0,0, 4,1,0,0,0); add(0,0,0,0, 5,1,1,0,0); add(0,0,0,0, 0,0,0,0,0);

    foreach (tbl[i]) apply(tbl[i], i);

    // 6: instruction count over 10 free-run instructions, then reset mid-instruction
    rst = 1'b1; exec = 1'b0; step = 1'b0; halt_i = 1'b0; mem_wait = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("cnt_after_rst", 0, 32'(instr_cnt), 32'd0);

    v = '{e:1, s:0, h:0, m:0, ph:1, run:1, pce:0, hl:0, wt:0};
    apply(v, 1000);
    for (int i = 0; i < 10; i++) begin
      v = '{e:(i == 9), s:0, h:0, m:0, ph:2, run:1, pce:0, hl:0, wt:0}; apply(v, 1001 + 5*i);
      v = '{e:0, s:0, h:0, m:0, ph:3, run:1, pce:0, hl:0, wt:0};        apply(v, 1002 + 5*i);
      v = '{e:0, s:0, h:0, m:0, ph:4, run:1, pce:0, hl:0, wt:0};        apply(v, 1003 + 5*i);
      v = '{e:0, s:0, h:0, m:0, ph:5, run:1, pce:1, hl:0, wt:0};        apply(v, 1004 + 5*i);
      v = '{e:0, s:0, h:0, m:0, ph:(i == 9) ? 0 : 1, run:(i != 9), pce:0, hl:0, wt:0};
      apply(v, 1005 + 5*i);
    end
`ifdef SEQ_INSTR_COUNT_EN
    exp_cnt = CNT_W'(10);
`else
    exp_cnt = '0;
`endif
    chk("instr_cnt_10", 0, 32'(instr_cnt), 32'(exp_cnt));

    v = '{e:1, s:0, h:0, m:0, ph:1, run:1, pce:0, hl:0, wt:0}; apply(v, 2000);
    v = '{e:0, s:0, h:0, m:0, ph:2, run:1, pce:0, hl:0, wt:0}; apply(v, 2001);
    v = '{e:0, s:0, h:0, m:0, ph:3, run:1, pce:0, hl:0, wt:0}; apply(v, 2002);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_phase",   0, 32'(phase),     32'd0);
    chk("midrst_running", 0, 32'(running),   32'd0);
    chk("midrst_pc_e",    0, 32'(pc_e),      32'd0);
    chk("midrst_cnt",     0, 32'(instr_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_pc_e2",   0, 32'(pc_e),      32'd0);
    chk("midrst_phase2",  0, 32'(phase),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
